// File: rtl/shr_seq.sv
// shr_seq: shift/rotate register with single-step and counted automatic modes.
// Loads (ld_fill, ld) take priority and abort an automatic run without a done pulse.
module shr_seq #(
    parameter int unsigned           WIDTH = 10,
    parameter logic [WIDTH-1:0]      FILL  = {WIDTH{1'b1}},
    parameter int unsigned           CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_fill,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             si,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;

    logic [1:0]       eff_mode;
    logic [WIDTH-1:0] step_val;

    // Effective mode: the latched copy while running, the live input otherwise.
    always_comb begin
        eff_mode = (state_q == RUN) ? mode_q : mode;
    end

    // One shift/rotate step of the current contents under the effective mode.
    always_comb begin
        step_val = q_q;
        case (eff_mode)
            2'b00:   step_val = {si, q_q[WIDTH-1:1]};
            2'b01:   step_val = {q_q[WIDTH-2:0], si};
            2'b10:   step_val = {q_q[0], q_q[WIDTH-1:1]};
            default: step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        endcase
    end

    // Next-state decode in priority order: load fill, load, run step, start, single step.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (ld_fill) begin
            q_d     = FILL;
            state_d = IDLE;
            rem_d   = '0;
        end else if (ld) begin
            q_d     = d;
            state_d = IDLE;
            rem_d   = '0;
        end else if (state_q == RUN) begin
            q_d   = step_val;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            if (count != '0) begin
                rem_d   = count;
                mode_d  = mode;
                state_d = RUN;
            end else begin
                done_d = 1'b1;
            end
        end else if (en) begin
            q_d = step_val;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            mode_q  <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign so   = eff_mode[0] ? q_q[WIDTH-1] : q_q[0];
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_shr_seq.sv
// Directed self-checking bench for shr_seq (WIDTH=10, CNT_W=4).
module tb_shr_seq;

    logic       clk;
    logic       rst;
    logic       ld_fill;
    logic       ld;
    logic [9:0] d;
    logic [1:0] mode;
    logic       en;
    logic       si;
    logic       start;
    logic [3:0] count;
    logic [9:0] q;
    logic       so;
    logic       busy;
    logic       done;

    int unsigned n_checks;
    int unsigned n_errors;

    shr_seq #(
        .WIDTH (10),
        .FILL  (10'h3FF),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_fill (ld_fill),
        .ld      (ld),
        .d       (d),
        .mode    (mode),
        .en      (en),
        .si      (si),
        .start   (start),
        .count   (count),
        .q       (q),
        .so      (so),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; ld_fill = 1'b0; ld = 1'b0; d = '0; mode = 2'b00;
        en = 1'b0; si = 1'b0; start = 1'b0; count = '0;

        // Reset state
        tick();
        rst = 1'b0;
        check_eq("rst_q", 32'(q), 32'h000);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_so", 32'(so), 0);

        // Load fill value
        ld_fill = 1'b1; tick(); ld_fill = 1'b0;
        check_eq("fill_q", 32'(q), 32'h3FF);
        check_eq("fill_busy", 32'(busy), 0);
        check_eq("fill_done", 32'(done), 0);

        // Single step shift right with si=1
        ld = 1'b1; d = 10'h001; tick(); ld = 1'b0;
        check_eq("ld_q", 32'(q), 32'h001);
        en = 1'b1; mode = 2'b00; si = 1'b1;
        #1 check_eq("en_so_pre", 32'(so), 1);
        tick(); en = 1'b0;
        check_eq("en_q", 32'(q), 32'h200);
        check_eq("en_done", 32'(done), 0);
        tick();
        check_eq("hold_q", 32'(q), 32'h200);

        // Counted rotate right by 3; start is accepted without shifting
        ld = 1'b1; d = 10'h201; tick(); ld = 1'b0;
        start = 1'b1; count = 4'd3; mode = 2'b10; tick(); start = 1'b0;
        check_eq("rr_acc_q", 32'(q), 32'h201);
        check_eq("rr_acc_busy", 32'(busy), 1);
        mode = 2'b00; si = 1'b0; en = 1'b1;  // live mode/en must not matter during RUN
        check_eq("rr_so_latched", 32'(so), 1);  // rotate right -> q[0]
        tick();
        check_eq("rr_s1_q", 32'(q), 32'h300);
        check_eq("rr_s1_busy", 32'(busy), 1);
        check_eq("rr_s1_done", 32'(done), 0);
        tick();
        check_eq("rr_s2_q", 32'(q), 32'h180);
        check_eq("rr_s2_busy", 32'(busy), 1);
        en = 1'b0;
        tick();
        check_eq("rr_s3_q", 32'(q), 32'h0C0);
        check_eq("rr_s3_busy", 32'(busy), 0);
        check_eq("rr_s3_done", 32'(done), 1);
        tick();
        check_eq("rr_post_q", 32'(q), 32'h0C0);
        check_eq("rr_post_done", 32'(done), 0);

        // Counted shift left by 10 with si=0, live mode toggled during the run
        ld_fill = 1'b1; tick(); ld_fill = 1'b0;
        start = 1'b1; count = 4'd10; mode = 2'b01; si = 1'b0; tick(); start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            mode = (i % 2 == 1) ? 2'b10 : 2'b00;
            if (i == 10) begin
                // q = 0x200 here; latched shift-left gives so=q[9]=1, live 00 would give 0
                check_eq("sl_so_latched", 32'(so), 1);
            end
            tick();
            if (i < 10) begin
                check_eq("sl_busy", 32'(busy), 1);
                check_eq("sl_done", 32'(done), 0);
            end
        end
        check_eq("sl_q", 32'(q), 32'h000);
        check_eq("sl_busy_end", 32'(busy), 0);
        check_eq("sl_done_end", 32'(done), 1);
        tick();
        check_eq("sl_done_clr", 32'(done), 0);

        // Abort a count=8 run with ld after 2 steps
        ld = 1'b1; d = 10'h0F0; tick(); ld = 1'b0;
        start = 1'b1; count = 4'd8; mode = 2'b00; si = 1'b0; tick(); start = 1'b0;
        tick();
        check_eq("ab_s1_q", 32'(q), 32'h078);
        tick();
        check_eq("ab_s2_q", 32'(q), 32'h03C);
        ld = 1'b1; d = 10'h155; tick(); ld = 1'b0;
        check_eq("ab_q", 32'(q), 32'h155);
        check_eq("ab_busy", 32'(busy), 0);
        check_eq("ab_done", 32'(done), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("ab_no_done", 32'(done), 0);
            check_eq("ab_hold_q", 32'(q), 32'h155);
        end

        // start with count=0: done pulse only
        start = 1'b1; count = 4'd0; tick(); start = 1'b0;
        check_eq("c0_done", 32'(done), 1);
        check_eq("c0_busy", 32'(busy), 0);
        check_eq("c0_q", 32'(q), 32'h155);
        tick();
        check_eq("c0_done_clr", 32'(done), 0);

        // Reset during RUN, then single steps with live mode
        start = 1'b1; count = 4'd5; mode = 2'b00; si = 1'b0; tick(); start = 1'b0;
        tick();
        check_eq("mr_s1_q", 32'(q), 32'h0AA);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("mr_q", 32'(q), 32'h000);
        check_eq("mr_busy", 32'(busy), 0);
        check_eq("mr_done", 32'(done), 0);
        en = 1'b1; mode = 2'b01; si = 1'b1;
        check_eq("mr_so_live", 32'(so), 0);
        tick();
        check_eq("mr_en1_q", 32'(q), 32'h001);
        tick();
        check_eq("mr_en2_q", 32'(q), 32'h003);
        check_eq("mr_en_busy", 32'(busy), 0);
        en = 1'b0; tick();
        check_eq("mr_hold_q", 32'(q), 32'h003);
        check_eq("mr_hold_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shr_seq.md
SHR_SEQ -- requirements
Module: shr_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 10, register width in bits (min 2).
REQ-002 SHALL provide parameter FILL, default {WIDTH{1'b1}}, value loaded by ld_fill.
REQ-003 SHALL provide parameter CNT_W, default 4, width of the shift-count input.
REQ-004 SHALL provide port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL provide port ld_fill  input  1  load FILL into q.
REQ-007 SHALL provide port ld  input  1  parallel load of d into q.
REQ-008 SHALL provide port d  input  WIDTH  parallel load data.
REQ-009 SHALL provide port mode  input  2  00 shift right, 01 shift left, 10 rotate right, 11 rotate left.
REQ-010 SHALL provide port en  input  1  single-step shift when idle.
REQ-011 SHALL provide port si  input  1  serial input for shift modes (ignored for rotate).
REQ-012 SHALL provide port start  input  1  begin an automatic multi-cycle shift of count steps.
REQ-013 SHALL provide port count  input  CNT_W  number of steps for start.
REQ-014 SHALL provide port q  output  WIDTH  register contents.
REQ-015 SHALL provide port so  output  1  bit the next step shifts out: q[0] for modes 00/10, q[WIDTH-1] for 01/11, using the effective mode (REQ-020).
REQ-016 SHALL provide port busy  output  1  automatic operation in progress.
REQ-017 SHALL provide port done  output  1  one-cycle pulse when an automatic operation completes.

Function
REQ-018 SHALL implement one step per mode: 00 q<={si,q[W-1:1]}; 01 q<={q[W-2:0],si}; 10 q<={q[0],q[W-1:1]}; 11 q<={q[W-2:0],q[W-1]}.
REQ-019 SHALL use a two-state FSM, IDLE and RUN, plus a CNT_W-bit remaining-steps counter.
REQ-020 SHALL latch mode at start acceptance; effective mode = latched mode in RUN, live mode in IDLE; mode changes during RUN have no effect.
REQ-021 SHALL apply per-edge priority: rst > ld_fill > ld > RUN step > start (IDLE) > en (IDLE) > hold.
REQ-022 SHALL, in IDLE with start=1 and count>0: no shift on that edge, remaining<=count, busy<=1, go RUN.
REQ-023 SHALL, in IDLE with start=1 and count=0: no shift, stay IDLE, done<=1 for one cycle.
REQ-024 SHALL, in RUN on each edge: perform one step, decrement remaining; when remaining==1 go IDLE, busy<=0, done<=1 on that edge.
REQ-025 SHALL keep busy high for exactly count cycles and assert done in the cycle after the last step.
REQ-026 SHALL ignore start and en while busy=1.
REQ-027 SHALL, on ld or ld_fill during RUN, perform the load, abort (go IDLE, busy<=0) and not assert done.
REQ-028 SHALL, in IDLE with en=1 and no higher-priority input, perform exactly one step per cycle using live mode; done not asserted.
REQ-029 SHALL hold q when no action applies; done deasserts after one cycle in every case.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set q=0, busy=0, done=0, remaining=0, FSM=IDLE, latched mode=00, regardless of state (including mid-RUN).
REQ-031 SHALL drive so per REQ-015 after reset (q=0 gives so=0).

Verification (WIDTH=10, CNT_W=4)
REQ-032 SHALL check: rst, then ld_fill 1 cycle -> q=0x3FF, busy=0, done=0.
REQ-033 SHALL check: ld d=0x001, then en=1 mode=00 si=1 for 1 cycle -> so=1 before the edge, q=0x200 after.
REQ-034 SHALL check: ld d=0x201, start count=3 mode=10 -> q 0x300, 0x180, 0x0C0 on successive edges; busy high 3 cycles; done high 1 cycle with q=0x0C0.
REQ-035 SHALL check: q=0x3FF, start count=10 mode=01 si=0, mode toggled during RUN -> q=0x000 after 10 steps, done pulse.
REQ-036 SHALL check: start count=8, after 2 steps ld d=0x155 -> q=0x155, busy=0 next cycle, done never asserted; start count=0 -> done pulse only, q unchanged.
REQ-037 SHALL check: rst asserted mid-RUN -> next cycle q=0, busy=0, done=0; subsequent en steps behave per REQ-028.
